// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-lane input scheduler for the 2:1 byte mux datapath.
// Each lane has a small FIFO. A round-robin arbiter pops at most one byte per
// cycle into a registered output with a valid flag. pause_out stalls pops.
// Optional build macro MUX_ARB_STRICT_PRIO_EN: lane 0 always wins when eligible.
module mux_rr_arbiter #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic              valid_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              valid_in_1,
    input  logic              pause_out,
    output logic              full_0,
    output logic              full_1,
    output logic [AW:0]       fifo_cnt_0,
    output logic [AW:0]       fifo_cnt_1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              grant_out,
    output logic [1:0]        err_overflow
);

    typedef enum logic [0:0] {StLast0 = 1'b0, StLast1 = 1'b1} arb_state_e;

    localparam logic [AW:0] CntFull = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem_0 [FIFO_DEPTH];
    logic [DATA_W-1:0] r_mem_1 [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr_0, r_rd_ptr_0, r_wr_ptr_1, r_rd_ptr_1;
    logic [AW:0]       r_cnt_0, r_cnt_1;
    arb_state_e        r_state, w_state_next;

    logic              w_elig_0, w_elig_1;
    logic              w_pop, w_grant;
    logic              w_push_0, w_push_1;
    logic              w_pop_0, w_pop_1;
    logic [DATA_W-1:0] w_head;

    assign full_0     = (r_cnt_0 == CntFull);
    assign full_1     = (r_cnt_1 == CntFull);
    assign fifo_cnt_0 = r_cnt_0;
    assign fifo_cnt_1 = r_cnt_1;

    // Full is judged on the pre-edge count, so a same-edge pop never frees a slot.
    assign w_push_0 = valid_in_0 & ~full_0;
    assign w_push_1 = valid_in_1 & ~full_1;
    assign w_elig_0 = (r_cnt_0 != '0) & ~pause_out;
    assign w_elig_1 = (r_cnt_1 != '0) & ~pause_out;
    assign w_pop_0  = w_pop & ~w_grant;
    assign w_pop_1  = w_pop & w_grant;
    assign w_head   = w_grant ? r_mem_1[r_rd_ptr_1] : r_mem_0[r_rd_ptr_0];

    // Arbitration and next-state: grant selection and last-granted tracking.
    always_comb begin
        w_pop        = 1'b0;
        w_grant      = 1'b0;
        w_state_next = r_state;
        if (w_elig_0 && w_elig_1) begin
            w_pop = 1'b1;
`ifdef MUX_ARB_STRICT_PRIO_EN
            w_grant = 1'b0;
`else
            w_grant = (r_state == StLast0);
`endif
        end else if (w_elig_0) begin
            w_pop   = 1'b1;
            w_grant = 1'b0;
        end else if (w_elig_1) begin
            w_pop   = 1'b1;
            w_grant = 1'b1;
        end
        if (w_pop) begin
            w_state_next = w_grant ? StLast1 : StLast0;
        end
    end

    // Arbiter state register; reset to LAST1 so lane 0 wins first.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= StLast1;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FIFO storage; contents are don't-care until counted, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push_0) r_mem_0[r_wr_ptr_0] <= data_in_0;
        if (w_push_1) r_mem_1[r_wr_ptr_1] <= data_in_1;
    end

    // FIFO pointers, occupancy counts and sticky overflow flags.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr_0   <= '0;
            r_rd_ptr_0   <= '0;
            r_wr_ptr_1   <= '0;
            r_rd_ptr_1   <= '0;
            r_cnt_0      <= '0;
            r_cnt_1      <= '0;
            err_overflow <= 2'b00;
        end else begin
            if (w_push_0) r_wr_ptr_0 <= r_wr_ptr_0 + 1'b1;
            if (w_push_1) r_wr_ptr_1 <= r_wr_ptr_1 + 1'b1;
            if (w_pop_0)  r_rd_ptr_0 <= r_rd_ptr_0 + 1'b1;
            if (w_pop_1)  r_rd_ptr_1 <= r_rd_ptr_1 + 1'b1;
            if (w_push_0 && !w_pop_0)      r_cnt_0 <= r_cnt_0 + 1'b1;
            else if (!w_push_0 && w_pop_0) r_cnt_0 <= r_cnt_0 - 1'b1;
            if (w_push_1 && !w_pop_1)      r_cnt_1 <= r_cnt_1 + 1'b1;
            else if (!w_push_1 && w_pop_1) r_cnt_1 <= r_cnt_1 - 1'b1;
            if (valid_in_0 && full_0) err_overflow[0] <= 1'b1;
            if (valid_in_1 && full_1) err_overflow[1] <= 1'b1;
        end
    end

    // Output register: capture the popped byte, else drop valid and hold data.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            grant_out <= 1'b0;
        end else begin
            valid_out <= w_pop;
            if (w_pop) begin
                data_out  <= w_head;
                grant_out <= w_grant;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed self-checking bench for mux_rr_arbiter.
// Honours MUX_ARB_STRICT_PRIO_EN for the expected pop orders.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] data_in_0, data_in_1;
    logic       valid_in_0, valid_in_1;
    logic       pause_out;
    logic       full_0, full_1;
    logic [2:0] fifo_cnt_0, fifo_cnt_1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       grant_out;
    logic [1:0] err_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // {grant, data} of each observed pop
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    mux_rr_arbiter #(
        .DATA_W    (8),
        .FIFO_DEPTH(4),
        .AW        (2)
    ) u_dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .data_in_0   (data_in_0),
        .valid_in_0  (valid_in_0),
        .data_in_1   (data_in_1),
        .valid_in_1  (valid_in_1),
        .pause_out   (pause_out),
        .full_0      (full_0),
        .full_1      (full_1),
        .fifo_cnt_0  (fifo_cnt_0),
        .fifo_cnt_1  (fifo_cnt_1),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .grant_out   (grant_out),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
    endtask

    // Push n bytes on selected lanes, bases b0/b1 incrementing.
    task automatic preload(input int n, input bit l0, input bit l1,
                           input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < n; i++) begin
            data_in_0  = b0 + 8'(i);
            data_in_1  = b1 + 8'(i);
            valid_in_0 = l0;
            valid_in_1 = l1;
            tick();
        end
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
    endtask

    // Collect up to n pops within max_cyc edges.
    task automatic collect(input int n, input int max_cyc);
        for (int c = 0; c < max_cyc && got_q.size() < n; c++) begin
            tick();
            if (valid_out) got_q.push_back({grant_out, data_out});
        end
    endtask

    task automatic compare_q(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_%0d", tag, i),
                     (i < got_q.size()) ? 32'(got_q[i]) : 32'hdead, 32'(exp_q[i]));
        end
    endtask

    // Expected order of two preloaded lanes (base0, base1), n bytes each.
    task automatic build_two_lane_exp(input int n, input logic [7:0] b0, input logic [7:0] b1);
        exp_q.delete();
`ifdef MUX_ARB_STRICT_PRIO_EN
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, b0 + 8'(i)});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, b1 + 8'(i)});
`else
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, b0 + 8'(i)});
            exp_q.push_back({1'b1, b1 + 8'(i)});
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        // Reset with inputs active, then idle.
        reset_L    = 1'b0;
        data_in_0  = 8'hff;
        data_in_1  = 8'hee;
        valid_in_0 = 1'b1;
        valid_in_1 = 1'b1;
        pause_out  = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_cnt0", fifo_cnt_0, 0);
        check_eq("rst_full1", full_1, 0);
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
        reset_L    = 1'b1;
        repeat (5) tick();
        check_eq("idle_outs", {data_out, valid_out, grant_out}, 0);
        check_eq("idle_err", err_overflow, 0);
        check_eq("idle_cnts", {fifo_cnt_0, fifo_cnt_1}, 0);

        // Single lane latency.
        data_in_0  = 8'hA5;
        valid_in_0 = 1'b1;
        tick();
        valid_in_0 = 1'b0;
        check_eq("lat_e1_valid", valid_out, 0);
        check_eq("lat_e1_cnt0", fifo_cnt_0, 1);
        tick();
        check_eq("lat_e2_out", {valid_out, grant_out, data_out}, {1'b1, 1'b0, 8'hA5});
        check_eq("lat_e2_cnt0", fifo_cnt_0, 0);
        tick();
        check_eq("lat_e3_valid", valid_out, 0);
        check_eq("lat_e3_hold", data_out, 8'hA5);

        // Fairness from reset state.
        do_reset();
        pause_out = 1'b1;
        preload(4, 1'b1, 1'b1, 8'h10, 8'h20);
        check_eq("fair_full", {full_0, full_1}, 2'b11);
        check_eq("fair_pause_valid", valid_out, 0);
        pause_out = 1'b0;
        got_q.delete();
        collect(8, 12);
        build_two_lane_exp(4, 8'h10, 8'h20);
        compare_q("fair");
        check_eq("fair_cnts", {fifo_cnt_0, fifo_cnt_1}, 0);

        // Overflow on lane 1.
        do_reset();
        pause_out = 1'b1;
        preload(4, 1'b0, 1'b1, 8'h00, 8'h30);
        check_eq("ovf_full1", full_1, 1);
        check_eq("ovf_cnt1", fifo_cnt_1, 4);
        check_eq("ovf_err_pre", err_overflow, 2'b00);
        preload(1, 1'b0, 1'b1, 8'h00, 8'h34);
        check_eq("ovf_err", err_overflow, 2'b10);
        check_eq("ovf_cnt1_sat", fifo_cnt_1, 4);
        pause_out = 1'b0;
        got_q.delete();
        collect(5, 10);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'h30 + 8'(i)});
        compare_q("ovf");
        check_eq("ovf_err_sticky", err_overflow, 2'b10);

        // Async reset mid-burst, without prior reset so the sticky flag is live.
        pause_out = 1'b1;
        preload(2, 1'b1, 1'b1, 8'h60, 8'h70);
        pause_out = 1'b0;
        tick();
        check_eq("arst_pre_valid", valid_out, 1);
        #3;
        reset_L = 1'b0;
        #1;
        check_eq("arst_outs", {data_out, valid_out, grant_out}, 0);
        check_eq("arst_cnts", {fifo_cnt_0, fifo_cnt_1}, 0);
        check_eq("arst_err", err_overflow, 2'b00);
        tick();
        reset_L = 1'b1;
        nv = 0;
        repeat (6) begin
            tick();
            if (valid_out) nv++;
        end
        check_eq("arst_no_stale", nv, 0);

        // Backpressure mid-stream.
        pause_out = 1'b1;
        preload(4, 1'b1, 1'b1, 8'h40, 8'h50);
        pause_out = 1'b0;
        got_q.delete();
        collect(3, 3);
        pause_out = 1'b1;
        nv = 0;
        repeat (3) begin
            tick();
            if (valid_out) nv++;
        end
        check_eq("bp_pause_valid", nv, 0);
        pause_out = 1'b0;
        collect(8, 10);
        build_two_lane_exp(4, 8'h40, 8'h50);
        compare_q("bp");
        check_eq("bp_cnts", {fifo_cnt_0, fifo_cnt_1}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
